// File: rtl/commit_trace_buffer.sv
// +----------------------------------------------------------------------+
// | Module      : commit_trace_buffer                                    |
// | Description : Writeback-commit trace recorder. Captures retired      |
// |               (pc, instruction, seq) triples into a circular buffer  |
// |               with wrap / stop-on-full modes, a pc-match trigger     |
// |               with post-trigger window, and retire/cycle counters    |
// |               with a cycle-budget timeout.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module commit_trace_buffer #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int CNT_W      = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 4,
  parameter int MAX_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_pc,
  input  logic [INST_W-1:0]          wb_instruction,
  input  logic                       mode,
  input  logic                       trig_en,
  input  logic [ADDR_W-1:0]          trig_pc,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          rd_pc,
  output logic [INST_W-1:0]          rd_instruction,
  output logic [CNT_W-1:0]           rd_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       triggered,
  output logic                       done,
  output logic [CNT_W-1:0]           retired_cnt,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic                       timeout
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_PST_W = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam int c_ENT_W = ADDR_W + INST_W + CNT_W;

  localparam logic [c_LVL_W-1:0] c_FULL   = c_LVL_W'(DEPTH);
  localparam logic [c_PST_W-1:0] c_POST   = c_PST_W'(POST_TRIG);
  localparam logic [c_PST_W-1:0] c_PST_1  = c_PST_W'(1);
  localparam logic [CNT_W-1:0]   c_MAXCYC = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PST_W-1:0]   r_post_cnt;
  logic [c_PST_W-1:0]   w_post_nxt;
  logic                 w_trig_set;

  logic [c_ENT_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_triggered;
  logic [CNT_W-1:0]     r_retired;
  logic [CNT_W-1:0]     r_cycles;

  logic                 w_cap_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_ovw;
  logic [c_ENT_W-1:0]   w_head;

  // A full buffer only blocks a capture in stop-on-full mode when no pop frees a slot.
  assign w_cap_req = wb_valid && (r_state != ST_FROZEN);
  assign w_pop     = rd_valid && rd_ready;
  assign w_full    = (r_count == c_FULL);
  assign w_drop    = w_cap_req && w_full && !w_pop && mode;
  assign w_push    = w_cap_req && !w_drop;
  assign w_ovw     = w_push && w_full && !w_pop;

  assign w_head         = r_mem[r_rd_ptr];
  assign rd_valid       = (r_count != '0);
  assign rd_pc          = w_head[c_ENT_W-1 -: ADDR_W];
  assign rd_instruction = w_head[CNT_W +: INST_W];
  assign rd_seq         = w_head[CNT_W-1:0];
  assign level          = r_count;
  assign overflow       = r_overflow;
  assign triggered      = r_triggered;
  assign retired_cnt    = r_retired;
  assign cycle_cnt      = r_cycles;
  assign timeout        = (r_cycles == c_MAXCYC);
  assign done           = (r_state == ST_FROZEN) || timeout;

  // Trace storage: written on every accepted capture, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wb_pc, wb_instruction, r_retired};
    end
  end

  // Pointers, occupancy and sticky overflow; an overwrite drags the read pointer along.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_ovw) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Saturating retire and cycle counters; retire counts even while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      if (wb_valid && (r_retired != '1)) begin
        r_retired <= r_retired + 1'b1;
      end
      if (r_cycles != c_MAXCYC) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  // Capture-control state register with post-trigger countdown and sticky trigger flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARMED;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_nxt;
      if (w_trig_set) begin
        r_triggered <= 1'b1;
      end
    end
  end

  // Next-state logic: trigger only in ARMED, countdown in POST, any dropped commit freezes.
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    w_trig_set  = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_drop) begin
          w_state_nxt = ST_FROZEN;
        end else if (w_push && trig_en && (wb_pc == trig_pc)) begin
          w_trig_set = 1'b1;
          if (POST_TRIG == 0) begin
            w_state_nxt = ST_FROZEN;
          end else begin
            w_state_nxt = ST_POST;
            w_post_nxt  = c_POST;
          end
        end
      end
      ST_POST: begin
        if (w_drop) begin
          w_state_nxt = ST_FROZEN;
        end else if (w_push) begin
          w_post_nxt = r_post_cnt - 1'b1;
          if (r_post_cnt == c_PST_1) begin
            w_state_nxt = ST_FROZEN;
          end
        end
      end
      ST_FROZEN: begin
        w_state_nxt = ST_FROZEN;
      end
      default: begin
        w_state_nxt = ST_ARMED;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// +----------------------------------------------------------------------+
// | Module      : tb_commit_trace_buffer                                 |
// | Description : Self-checking bench for commit_trace_buffer using a    |
// |               queue-based reference model, directed scenarios and    |
// |               randomized traffic.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_commit_trace_buffer;

  localparam int c_D   = 16;
  localparam int c_PT  = 4;
  localparam int c_MC  = 8;
  localparam int c_MCL = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instruction;
  logic        mode;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_ready;

  logic        rd_valid, overflow, triggered, done, timeout;
  logic [31:0] rd_pc, rd_instruction, rd_seq, retired_cnt, cycle_cnt;
  logic [4:0]  level;

  logic        rd_valid_l, overflow_l, triggered_l, done_l, timeout_l;
  logic [31:0] rd_pc_l, rd_instruction_l, rd_seq_l, retired_cnt_l, cycle_cnt_l;
  logic [4:0]  level_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_instruction(wb_instruction), .mode(mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_instruction(rd_instruction), .rd_seq(rd_seq),
    .level(level), .overflow(overflow), .triggered(triggered), .done(done),
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt), .timeout(timeout)
  );

  commit_trace_buffer #(.MAX_CYCLES(c_MCL)) dut_l (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_instruction(wb_instruction), .mode(mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid_l),
    .rd_pc(rd_pc_l), .rd_instruction(rd_instruction_l), .rd_seq(rd_seq_l),
    .level(level_l), .overflow(overflow_l), .triggered(triggered_l), .done(done_l),
    .retired_cnt(retired_cnt_l), .cycle_cnt(cycle_cnt_l), .timeout(timeout_l)
  );

  // Reference model: trace contents as a queue of records, capture phase as a small integer.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] seq;
  } ent_t;

  localparam int M_ARMED  = 0;
  localparam int M_POST   = 1;
  localparam int M_FROZEN = 2;

  ent_t        m_q[$];
  int          m_phase;
  int          m_left;
  bit          m_trig;
  bit          m_ovf;
  logic [31:0] m_ret;
  int          m_cyc;
  int          m_cyc_l;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   pop, full;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_phase = M_ARMED;
      m_left  = 0;
      m_trig  = 0;
      m_ovf   = 0;
      m_ret   = 0;
      m_cyc   = 0;
      m_cyc_l = 0;
      return;
    end
    full = (m_q.size() == c_D);
    pop  = (m_q.size() > 0) && rd_ready;
    if (pop) void'(m_q.pop_front());
    if (wb_valid && m_phase != M_FROZEN) begin
      if (full && !pop && mode) begin
        m_phase = M_FROZEN;
      end else begin
        if (full && !pop) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
        e.pc = wb_pc; e.ins = wb_instruction; e.seq = m_ret;
        m_q.push_back(e);
        if (m_phase == M_ARMED && trig_en && wb_pc == trig_pc) begin
          m_trig = 1;
          if (c_PT == 0) m_phase = M_FROZEN;
          else begin
            m_phase = M_POST;
            m_left  = c_PT;
          end
        end else if (m_phase == M_POST) begin
          m_left--;
          if (m_left == 0) m_phase = M_FROZEN;
        end
      end
    end
    if (wb_valid && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
    if (m_cyc < c_MC) m_cyc++;
    if (m_cyc_l < c_MCL) m_cyc_l++;
  endtask

  task automatic compare_all();
    bit fz;
    fz = (m_phase == M_FROZEN);
    check_val("rd_valid", 64'(rd_valid), 64'(m_q.size() > 0));
    check_val("level", 64'(level), 64'(m_q.size()));
    if (m_q.size() > 0) begin
      check_val("rd_pc", 64'(rd_pc), 64'(m_q[0].pc));
      check_val("rd_instruction", 64'(rd_instruction), 64'(m_q[0].ins));
      check_val("rd_seq", 64'(rd_seq), 64'(m_q[0].seq));
    end
    check_val("overflow", 64'(overflow), 64'(m_ovf));
    check_val("triggered", 64'(triggered), 64'(m_trig));
    check_val("retired_cnt", 64'(retired_cnt), 64'(m_ret));
    check_val("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    check_val("timeout", 64'(timeout), 64'(m_cyc == c_MC));
    check_val("done", 64'(done), 64'(fz || (m_cyc == c_MC)));
    check_val("cycle_cnt_long", 64'(cycle_cnt_l), 64'(m_cyc_l));
    check_val("timeout_long", 64'(timeout_l), 64'(m_cyc_l == c_MCL));
    check_val("done_long", 64'(done_l), 64'(fz || (m_cyc_l == c_MCL)));
    check_val("level_long", 64'(level_l), 64'(m_q.size()));
  endtask

  // One clock: apply inputs, advance model, sample outputs just after the edge.
  task automatic step(input bit rs, input bit v, input logic [31:0] pc, input bit rr);
    rst            = rs;
    wb_valid       = v;
    wb_pc          = pc;
    wb_instruction = $urandom;
    rd_ready       = rr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
  endtask

  initial begin
    rst = 1; wb_valid = 0; wb_pc = 0; wb_instruction = 0;
    mode = 0; trig_en = 0; trig_pc = 0; rd_ready = 0;
    model_step();
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Basic capture in wrap mode, then drain.
    for (int i = 0; i < 3; i++) step(0, 1, 32'(i * 4), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    // Wrap with overwrite: 20 commits, no reads, then drain.
    do_reset();
    mode = 0;
    for (int i = 0; i < 20; i++) step(0, 1, 32'(i * 4), 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);

    // Stop-on-full: 17th commit dropped and freezes.
    do_reset();
    mode = 1;
    for (int i = 0; i < 17; i++) step(0, 1, 32'(i * 4), 0);
    step(0, 1, 32'h100, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);

    // Trigger at pc 0x20 with four post-trigger commits.
    do_reset();
    mode = 0; trig_en = 1; trig_pc = 32'h20;
    for (int i = 0; i < 20; i++) step(0, 1, 32'(i * 4), 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1);

    // Full in stop mode with simultaneous push and pop, then reset mid-POST.
    do_reset();
    mode = 1; trig_en = 0;
    for (int i = 0; i < 16; i++) step(0, 1, 32'(i * 4), 0);
    step(0, 1, 32'h40, 1);
    step(0, 1, 32'h44, 1);
    trig_en = 1; trig_pc = 32'h48;
    step(0, 1, 32'h48, 1);
    step(0, 1, 32'h4c, 1);
    step(1, 1, 32'h50, 1);
    step(0, 0, 0, 1);

    // Timeout with no commits.
    do_reset();
    trig_en = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

    // Randomized traffic.
    for (int r = 0; r < 8; r++) begin
      int vp, rp;
      mode    = 1'($urandom_range(0, 1));
      trig_en = 1'($urandom_range(0, 1));
      trig_pc = 32'($urandom_range(0, 15) * 4);
      vp      = $urandom_range(40, 95);
      rp      = $urandom_range(5, 80);
      do_reset();
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 49) == 0) mode = ~mode;
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 99) < vp),
             32'($urandom_range(0, 15) * 4),
             ($urandom_range(0, 99) < rp));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
